alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the 8-bit registered ALU: WIDTH-bit operands, 16 opcodes, registered result with carry/zero flags.
- Single-cycle ops complete in 1 cycle. Multiply ops run on an iterative shift-add engine controlled by a small FSM.
- Valid/ready on both input and output, so it can sit between pipeline stages of a datapath or a test harness with backpressure.

---
 rtl/alu_pipe.sv | 165 ++++++++++++++++
 tb/tb_alu_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with a registered result and carry/zero flags.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for ops 2/3.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_Sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_Out,
   output logic             CarryOut,
   output logic             Zero,
   output logic             busy
);

   logic             accept;
   logic             is_mul;
   logic             slot_free;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] r_res;
   logic             r_c;

   assign sum       = {1'b0, A} + {1'b0, B};
   assign diff      = {1'b0, A} - {1'b0, B};
   assign slot_free = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   always_comb begin
      r_res = '0;
      r_c   = 1'b0;
      unique case (ALU_Sel)
         4'd0: begin
            r_res = sum[WIDTH-1:0];
            r_c   = sum[WIDTH];
         end
         4'd1: begin
            r_res = diff[WIDTH-1:0];
            r_c   = diff[WIDTH];
         end
         // illegal-op marker when no multiplier is built
         4'd2, 4'd3: begin
            r_res = '0;
            r_c   = 1'b1;
         end
         4'd4: begin
            r_res = {A[WIDTH-2:0], 1'b0};
            r_c   = A[WIDTH-1];
         end
         4'd5: begin
            r_res = {1'b0, A[WIDTH-1:1]};
            r_c   = A[0];
         end
         4'd6:  r_res = {A[WIDTH-2:0], A[WIDTH-1]};
         4'd7:  r_res = {A[0], A[WIDTH-1:1]};
         4'd8:  r_res = A & B;
         4'd9:  r_res = A | B;
         4'd10: r_res = A ^ B;
         4'd11: r_res = ~(A | B);
         4'd12: r_res = ~(A & B);
         4'd13: r_res = ~(A ^ B);
         4'd14: r_res = {{(WIDTH-1){1'b0}}, A > B};
         4'd15: r_res = {{(WIDTH-1){1'b0}}, A == B};
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {IDLE, MUL} state_t;

   state_t             state;
   state_t             state_nx;
   logic               mul_done;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   cnt;
   logic               hi_sel;
   logic [WIDTH-1:0]   mul_res;
   logic               cnt_end;

   assign is_mul   = (ALU_Sel == 4'd2) || (ALU_Sel == 4'd3);
   assign in_ready = (state == IDLE) && slot_free;
   assign busy     = (state != IDLE);
   assign cnt_end  = (cnt == CNT_W'(WIDTH));
   assign mul_res  = hi_sel ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mul_done = 1'b0;
      unique case (state)
         IDLE: if (accept && is_mul) state_nx = MUL;
         MUL: begin
            // completion waits for an empty output slot
            if (cnt_end && !out_valid) begin
               mul_done = 1'b1;
               state_nx = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         hi_sel <= 1'b0;
      end else if (accept && is_mul) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         cnt    <= '0;
         hi_sel <= ALU_Sel[0];
      end else if (state == MUL && !cnt_end) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign in_ready = slot_free;
   assign busy     = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         ALU_Out   <= '0;
         CarryOut  <= 1'b0;
         Zero      <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept && !is_mul) begin
            ALU_Out   <= r_res;
            CarryOut  <= r_c;
            Zero      <= (r_res == '0);
            out_valid <= 1'b1;
         end
`ifdef ALU_PIPE_MUL_EN
         if (mul_done) begin
            ALU_Out   <= mul_res;
            CarryOut  <= 1'b0;
            Zero      <= (mul_res == '0);
            out_valid <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with hand-computed results for alu_pipe.
// Multiply checks follow whichever ALU_PIPE_MUL_EN build is compiled.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] ALU_Sel;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] ALU_Out;
   logic       CarryOut;
   logic       Zero;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8)) dut (
      .clock    (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .ALU_Sel  (ALU_Sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ALU_Out  (ALU_Out),
      .CarryOut (CarryOut),
      .Zero     (Zero),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] sel, input logic [7:0] a,
                        input logic [7:0] b);
      in_valid = 1'b1;
      ALU_Sel  = sel;
      A        = a;
      B        = b;
   endtask

   initial begin
      int lat;
      reset     = 1'b1;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      ALU_Sel   = '0;
      out_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_out",   32'(ALU_Out),   32'd0);
      chk("rst_carry", 32'(CarryOut),  32'd0);
      chk("rst_zero",  32'(Zero),      32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ready", 32'(in_ready),  32'd1);

      // ADD with carry out
      drive(4'd0, 8'hF0, 8'h20);
      step();
      in_valid = 1'b0;
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_out",   32'(ALU_Out),   32'h10);
      chk("add_carry", 32'(CarryOut),  32'd1);
      chk("add_zero",  32'(Zero),      32'd0);

      drive(4'd1, 8'd5, 8'd7);
      step();
      in_valid = 1'b0;
      chk("sub_out",   32'(ALU_Out),  32'hFE);
      chk("sub_borrow",32'(CarryOut), 32'd1);

      drive(4'd1, 8'd9, 8'd9);
      step();
      in_valid = 1'b0;
      chk("sub0_out",  32'(ALU_Out),  32'd0);
      chk("sub0_zero", 32'(Zero),     32'd1);
      chk("sub0_c",    32'(CarryOut), 32'd0);

      // back-to-back stream
      drive(4'd4, 8'h81, 8'h00);
      step();
      drive(4'd7, 8'h01, 8'h00);
      chk("shl_out", 32'(ALU_Out),  32'h02);
      chk("shl_c",   32'(CarryOut), 32'd1);
      step();
      drive(4'd13, 8'h0F, 8'h0F);
      chk("ror_out", 32'(ALU_Out),   32'h80);
      chk("ror_c",   32'(CarryOut),  32'd0);
      chk("ror_v",   32'(out_valid), 32'd1);
      step();
      drive(4'd14, 8'd5, 8'd3);
      chk("xnor_out", 32'(ALU_Out),  32'hFF);
      chk("xnor_c",   32'(CarryOut), 32'd0);
      step();
      drive(4'd15, 8'd5, 8'd3);
      chk("gt_out", 32'(ALU_Out), 32'd1);
      step();
      in_valid = 1'b0;
      chk("eq_out",  32'(ALU_Out), 32'd0);
      chk("eq_zero", 32'(Zero),    32'd1);
      step();
      chk("drain_v", 32'(out_valid), 32'd0);

      // backpressure holds result and blocks input
      out_ready = 1'b0;
      drive(4'd0, 8'd1, 8'd1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready", 32'(in_ready),  32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_out",   32'(ALU_Out),   32'd2);
         drive(4'd9, 8'hAA, 8'h55);
         step();
         in_valid = 1'b0;
      end
      chk("bp_hold", 32'(ALU_Out), 32'd2);
      out_ready = 1'b1;
      drive(4'd8, 8'hFF, 8'h3C);
      #1;
      chk("bp_release", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_next_out", 32'(ALU_Out),   32'h3C);
      chk("bp_next_v",   32'(out_valid), 32'd1);

      // reset wins over a simultaneous input
      reset = 1'b1;
      drive(4'd0, 8'd3, 8'd4);
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rstv_valid", 32'(out_valid), 32'd0);
      chk("rstv_out",   32'(ALU_Out),   32'd0);

`ifdef ALU_PIPE_MUL_EN
      drive(4'd3, 8'hC8, 8'h64);
      step();
      in_valid = 1'b0;
      chk("mulhi_busy",  32'(busy),     32'd1);
      chk("mulhi_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      chk("mulhi_lat",  32'(lat),      32'd9);
      chk("mulhi_out",  32'(ALU_Out),  32'h4E);
      chk("mulhi_c",    32'(CarryOut), 32'd0);
      chk("mulhi_idle", 32'(busy),     32'd0);

      drive(4'd2, 8'hC8, 8'h64);
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      chk("mullo_lat", 32'(lat),     32'd9);
      chk("mullo_out", 32'(ALU_Out), 32'h20);

      // abort a multiply with reset
      step();
      drive(4'd2, 8'hC8, 8'h64);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_valid", 32'(out_valid), 32'd0);
      drive(4'd0, 8'd3, 8'd4);
      step();
      in_valid = 1'b0;
      chk("abort_add", 32'(ALU_Out), 32'd7);
`else
      drive(4'd2, 8'hC8, 8'h64);
      step();
      in_valid = 1'b0;
      chk("nomul_valid", 32'(out_valid), 32'd1);
      chk("nomul_out",   32'(ALU_Out),   32'd0);
      chk("nomul_c",     32'(CarryOut),  32'd1);
      chk("nomul_zero",  32'(Zero),      32'd1);
      chk("nomul_busy",  32'(busy),      32'd0);
      drive(4'd0, 8'd3, 8'd4);
      step();
      in_valid = 1'b0;
      chk("nomul_add", 32'(ALU_Out), 32'd7);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
